uart_tx_fifo: RTL and testbench

//  Buffered UART transmit path: the send-side counterpart to the receiver's ready/ready_clr byte handshake.

---
 rtl/uart_tx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a baud-timed 8N1 frame serialiser (LSB first).
// Optional even-parity bit between D7 and stop when UART_TX_PARITY_EN is defined.
//
// state    | meaning
// S_IDLE   | line high, waiting for a queued byte
// S_START  | start bit (Tx=0)
// S_DATA   | eight data bits, shift[0] on the line
// S_PARITY | even parity of the byte (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (Tx=1); chains straight into the next start if FIFO has data
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_50m,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          wr_en,
    input  logic                          clear,
    output logic                          Tx,
    output logic                          Tx_busy,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int DIV    = CLK_HZ / BAUD;
    localparam int BAUD_W = $clog2(DIV);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [BAUD_W-1:0] DIV_M1 = BAUD_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              tx_q;
    logic              fifo_empty;
    logic              bit_done;
    logic              push;
    logic              pop;
    logic [7:0]        head;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign fifo_empty = (fifo_count == '0);
    assign full       = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign bit_done   = (baud_cnt == '0);
    assign head       = mem[rd_ptr];
    assign push       = !clear && wr_en && !full;
    // Pop is only taken where the FSM loads the shift register.
    assign pop        = !clear && !fifo_empty &&
                        ((state == S_IDLE) || (state == S_STOP && bit_done));

    assign Tx      = tx_q;
    assign Tx_busy = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk_50m) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            // A dropped write is flagged even if a pop frees space on the same edge.
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (clear) begin
            state    <= S_IDLE;
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift    <= head;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^head;
`endif
                        tx_q     <= 1'b0;
                        baud_cnt <= DIV_M1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        tx_q     <= shift[0];
                        bit_idx  <= '0;
                        baud_cnt <= DIV_M1;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        baud_cnt <= DIV_M1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q  <= parity_bit;
                            state <= S_PARITY;
`else
                            tx_q  <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        tx_q     <= 1'b1;
                        baud_cnt <= DIV_M1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift    <= head;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^head;
`endif
                            tx_q     <= 1'b0;
                            baud_cnt <= DIV_M1;
                            state    <= S_START;
                        end else begin
                            tx_q  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DIV=10: a line monitor decodes frames and compares them
// against bytes queued at write time; direct checks cover latency, full/overflow, clear and reset.
module tb_uart_tx_fifo;
    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = 10;
    localparam int DEPTH  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       wr_en;
    logic       clear;
    logic       Tx;
    logic       Tx_busy;
    logic       full;
    logic [3:0] fifo_count;
    logic       overflow;

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .clear      (clear),
        .Tx         (Tx),
        .Tx_busy    (Tx_busy),
        .full       (full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk_50m = ~clk_50m;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [7:0] sb[$];
    int         starts[$];
    bit         mon_en    = 1'b0;
    int         mon_state = 0;
    int         mon_cnt   = 0;
    logic [NB-1:0] bits;
    logic [7:0]    exp_b;

    always @(posedge clk_50m) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line monitor: samples each bit at its centre, frame starts recorded in cycles.
    always @(negedge clk_50m) begin
        if (!mon_en) begin
            mon_state = 0;
        end else if (mon_state == 0) begin
            if (Tx == 1'b0) begin
                mon_state = 1;
                mon_cnt   = 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % DIV == DIV / 2) begin
                bits[mon_cnt / DIV] = Tx;
                if (mon_cnt / DIV == NB - 1) begin
                    mon_state = 0;
                    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp_b = sb.pop_front();
                        check("frame_start", 32'(bits[0]), 32'd0);
                        check("frame_data", 32'(bits[8:1]), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", 32'(bits[9]), 32'(^exp_b));
`endif
                        check("frame_stop", 32'(bits[NB-1]), 32'd1);
                    end
                end
            end
        end
    end

    // Called at a negedge; leaves wr_en high for exactly one rising edge.
    task automatic write_byte(input logic [7:0] b, input bit expect_tx);
        data_in = b;
        wr_en   = 1'b1;
        if (expect_tx)
            sb.push_back(b);
        @(negedge clk_50m);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (Tx_busy && n < max) begin
            @(negedge clk_50m);
            n++;
        end
        check("idle_timeout", 32'(Tx_busy), 32'd0);
        @(negedge clk_50m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] b;
        rst_n   = 1'b0;
        data_in = 8'h00;
        wr_en   = 1'b0;
        clear   = 1'b0;
        repeat (3) @(negedge clk_50m);
        check("rst_tx", 32'(Tx), 32'd1);
        check("rst_busy", 32'(Tx_busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_50m);

        // Single byte: latency and total busy time.
        data_in = 8'hA5;
        wr_en   = 1'b1;
        sb.push_back(8'hA5);
        @(posedge clk_50m); #1;
        check("lat_count", 32'(fifo_count), 32'd1);
        check("lat_tx_hold", 32'(Tx), 32'd1);
        @(negedge clk_50m);
        wr_en = 1'b0;
        @(posedge clk_50m); #1;
        check("lat_tx_fall", 32'(Tx), 32'd0);
        check("lat_busy", 32'(Tx_busy), 32'd1);
        check("lat_count_pop", 32'(fifo_count), 32'd0);
        n = 1;
        while (Tx_busy && n < 300) begin
            @(posedge clk_50m); #1;
            n++;
        end
        check("busy_fall_cycles", 32'(n), 32'(NB * DIV + 1));
        @(negedge clk_50m);

        // Burst: lead byte on the line, then fill the FIFO and overflow it.
        starts.delete();
        write_byte(8'hFF, 1'b1);
        repeat (3) @(negedge clk_50m);
        for (int i = 0; i < DEPTH; i++)
            write_byte(8'(i), 1'b1);
        check("burst_full", 32'(full), 32'd1);
        check("burst_count", 32'(fifo_count), 32'd8);
        write_byte(8'hEE, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd8);
        n = 0;
        while (fifo_count == 4'd8 && n < NB * DIV + 10) begin
            @(negedge clk_50m);
            n++;
        end
        check("pop_dec", 32'(fifo_count), 32'd7);
        check("pop_not_full", 32'(full), 32'd0);
        wait_idle(NB * DIV * 10 + 50);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("burst_drained", 32'(fifo_count), 32'd0);
        check("burst_frames", 32'(starts.size()), 32'd9);
        for (int i = 1; i < starts.size(); i++)
            check("frame_gap", 32'(starts[i] - starts[i-1]), 32'(NB * DIV));

        // Clear in the middle of a data bit with bytes queued.
        mon_en = 1'b0;
        write_byte(8'h3C, 1'b0);
        repeat (DIV * 3) @(negedge clk_50m);
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        write_byte(8'h33, 1'b0);
        check("clr_pre_count", 32'(fifo_count), 32'd3);
        check("clr_pre_ovf", 32'(overflow), 32'd1);
        clear   = 1'b1;
        wr_en   = 1'b1;
        data_in = 8'h99;
        @(posedge clk_50m); #1;
        check("clr_tx", 32'(Tx), 32'd1);
        check("clr_count", 32'(fifo_count), 32'd0);
        check("clr_busy", 32'(Tx_busy), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        @(negedge clk_50m);
        clear = 1'b0;
        wr_en = 1'b0;
        repeat (DIV * 2) @(negedge clk_50m);
        check("clr_stay_tx", 32'(Tx), 32'd1);
        check("clr_stay_count", 32'(fifo_count), 32'd0);
        mon_en = 1'b1;

        // Asynchronous reset mid-frame, then a fresh frame.
        mon_en = 1'b0;
        write_byte(8'h81, 1'b0);
        repeat (DIV * 3 + 2) @(negedge clk_50m);
        check("rst_mid_tx_low", 32'(Tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_tx", 32'(Tx), 32'd1);
        check("rst_async_busy", 32'(Tx_busy), 32'd0);
        check("rst_async_count", 32'(fifo_count), 32'd0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        @(negedge clk_50m);
        mon_en = 1'b1;
        write_byte(8'h55, 1'b1);
        wait_idle(NB * DIV + 50);

        // Random bytes with random spacing.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            write_byte(b, 1'b1);
            repeat ($urandom_range(0, 150)) @(negedge clk_50m);
        end
        wait_idle(NB * DIV * 5 + 50);

`ifdef UART_TX_PARITY_EN
        starts.delete();
        write_byte(8'h07, 1'b1);
        write_byte(8'h03, 1'b1);
        wait_idle(NB * DIV * 3 + 50);
        check("par_frames", 32'(starts.size()), 32'd2);
        if (starts.size() == 2)
            check("par_frame_len", 32'(starts[1] - starts[0]), 32'd110);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
